mc_exec_controller: RTL
=======================

// Module: mc_exec_controller
// PURPOSE
//  Multicycle sequencer for the LEGv8 execute datapath (sign-extend/shift, branch adder, ALU-source mux, ALU).
//  Decodes the latched opcode, steps FETCH->DECODE->EXEC->MEM->WB, and drives AluSrc, AluControl and the
//  PC/IR/regfile/memory enables each cycle. Waits on instruction/data memory ready handshakes.
//  Sits between the instruction register and the shared single-ALU datapath of the multicycle core.
// PARAMETERS
//  OPW   11  opcode width (instr[31:21])
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  opcode      in   11  instr[31:21] from IR, stable from DECODE until next FETCH
//  zero_E      in   1   ALU zero flag from execute datapath
//  imem_ready  in   1   instruction word valid this cycle
//  dmem_ready  in   1   data read/write completes this cycle
//  PcWrite     out  1   load PC
//  PcSrc       out  1   0: PC+4, 1: PCBranch_E
//  IrWrite     out  1   load IR
//  AluSrc      out  1   0: readData2, 1: signImm
//  AluControl  out  4   0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
//  RegWrite    out  1   register file write
//  MemRead     out  1   data memory read request
//  MemWrite    out  1   data memory write request
//  MemtoReg    out  1   0: aluResult, 1: readData
//  busy        out  1   high in every state except FETCH
// BEHAVIOUR
//  Moore FSM; all outputs decoded from state (+ latched class, zero_E in BRANCH). Reset: state=FETCH, all outputs 0.
//  Opcode classes (decoded in DECODE, latched): ADD 10001011000, SUB 11001011000, AND 10001010000,
//   ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ opcode[10:3]=10110100, B opcode[10:5]=000101.
//  FETCH: MemRead-style wait; when imem_ready: IrWrite=1, PcWrite=1, PcSrc=0 -> DECODE; else hold, no enables.
//  DECODE: no enables; R-class->EXEC_R, LDUR/STUR->ADDR, CBZ/B->BRANCH, unknown->FETCH (NOP, ignored).
//  EXEC_R: AluSrc=0, AluControl per class -> WB_R.   WB_R: RegWrite=1, MemtoReg=0 -> FETCH.
//  ADDR: AluSrc=1, AluControl=0010 -> MEM_RD (LDUR) / MEM_WR (STUR).
//  MEM_RD: MemRead=1 held until dmem_ready, then -> WB_MEM.  WB_MEM: RegWrite=1, MemtoReg=1 -> FETCH.
//  MEM_WR: MemWrite=1 held until dmem_ready, then -> FETCH. AluSrc=1/AluControl=0010 held during MEM_*.
//  BRANCH: AluSrc=0, AluControl=0111; PcSrc=1; PcWrite=1 if B, or CBZ and zero_E=1 (same cycle) -> FETCH.
//  Latency at zero wait-state: R 4, LDUR 5, STUR 4, CBZ/B 3 cycles; each ready-low cycle adds one.
//  RegWrite/MemWrite/PcWrite never asserted in same cycle as reset; reset mid-instruction aborts it, no
//   partial write after reset deasserts. Ready asserted in a state not waiting on it is ignored.
// CONFIGURATION
//  MC_EXC_EN defined: extra outputs Exc (1) and ExcCause (2); unknown opcode in DECODE -> EXC state:
//   Exc=1, ExcCause=01, PcWrite=0, one cycle, then halts in EXC until reset. Not defined: unknown
//   opcode is a NOP (DECODE->FETCH), ports absent.
// STRUCTURE
//  mc_pkg: state_t enum, class_t enum, opcode constants, ALUCTL_* 4-bit constants, EXC cause codes.
//  Sub-module mc_alu_decoder: combinational class_t -> AluControl; FSM instantiates it once.
// TESTING
//  ADD (10001011000), ready=1 -> IrWrite@c0, AluControl=0010/AluSrc=0@c2, RegWrite@c3, FETCH@c4.
//  LDUR, dmem_ready low 3 cycles -> MemRead held 4 cycles, then RegWrite=1,MemtoReg=1 once; 8 cycles total.
//  CBZ zero_E=1 -> PcWrite=1,PcSrc=1 in BRANCH; zero_E=0 -> PcWrite=0; both 3 cycles, AluControl=0111.
//  STUR with reset asserted during MEM_WR -> next cycle FETCH, all outputs 0, no MemWrite after reset.
//  imem_ready=0 for 5 cycles in FETCH -> no IrWrite/PcWrite, busy=0; opcode 11111111111 -> NOP / EXC (MC_EXC_EN).

Source files
------------

// File: rtl/mc_exec_controller_pkg.sv
// Shared types and constants for the LEGv8 multicycle execute controller.
// State/class encodings, opcode patterns, ALU control codes and per-state control decode.
package mc_exec_controller_pkg;

  localparam int OPW = 11;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_ADDR,
    ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_BRANCH, ST_EXC
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_LDUR, CL_STUR, CL_CBZ, CL_B
  } class_t;

  localparam logic [OPW-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPW-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPW-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPW-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPW-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPW-1:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]     OP_CBZ_HI = 8'b10110100;
  localparam logic [5:0]     OP_B_HI   = 6'b000101;

  localparam logic [3:0] ALUCTL_AND   = 4'b0000;
  localparam logic [3:0] ALUCTL_ORR   = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD   = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB   = 4'b0110;
  localparam logic [3:0] ALUCTL_PASSB = 4'b0111;

  localparam logic [1:0] EXC_NONE       = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL_OP = 2'b01;

  // Control bits that are a pure function of the state and can be registered ahead.
  typedef struct packed {
    logic fetch;
    logic branch;
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic busy;
  } ctrl_t;

  function automatic class_t decode_class(input logic [OPW-1:0] op);
    class_t c;
    if (op == OP_ADD)                c = CL_ADD;
    else if (op == OP_SUB)           c = CL_SUB;
    else if (op == OP_AND)           c = CL_AND;
    else if (op == OP_ORR)           c = CL_ORR;
    else if (op == OP_LDUR)          c = CL_LDUR;
    else if (op == OP_STUR)          c = CL_STUR;
    else if (op[10:3] == OP_CBZ_HI)  c = CL_CBZ;
    else if (op[10:5] == OP_B_HI)    c = CL_B;
    else                             c = CL_NOP;
    return c;
  endfunction

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '{default: 1'b0};
    c.busy = (s != ST_FETCH);
    case (s)
      ST_FETCH:  c.fetch = 1'b1;
      ST_WB_R:   c.regwrite = 1'b1;
      ST_ADDR:   c.alusrc = 1'b1;
      ST_MEM_RD: begin c.alusrc = 1'b1; c.memread = 1'b1; end
      ST_WB_MEM: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      ST_MEM_WR: begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      ST_BRANCH: c.branch = 1'b1;
      default:   c.fetch = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic state_uses_alu(input state_t s);
    logic u;
    case (s)
      ST_EXEC_R, ST_ADDR, ST_MEM_RD, ST_MEM_WR, ST_BRANCH: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/mc_exec_controller_if.sv
// Controller <-> datapath/memory bundle. Exc/ExcCause exist only when MC_EXC_EN is defined.
interface mc_exec_controller_if;
  import mc_exec_controller_pkg::*;

  logic [OPW-1:0] opcode;
  logic           zero_E;
  logic           imem_ready;
  logic           dmem_ready;
  logic           PcWrite;
  logic           PcSrc;
  logic           IrWrite;
  logic           AluSrc;
  logic [3:0]     AluControl;
  logic           RegWrite;
  logic           MemRead;
  logic           MemWrite;
  logic           MemtoReg;
  logic           busy;
`ifdef MC_EXC_EN
  logic           Exc;
  logic [1:0]     ExcCause;

  modport slave (
    input  opcode, zero_E, imem_ready, dmem_ready,
    output PcWrite, PcSrc, IrWrite, AluSrc, AluControl, RegWrite,
           MemRead, MemWrite, MemtoReg, busy, Exc, ExcCause
  );
  modport master (
    output opcode, zero_E, imem_ready, dmem_ready,
    input  PcWrite, PcSrc, IrWrite, AluSrc, AluControl, RegWrite,
           MemRead, MemWrite, MemtoReg, busy, Exc, ExcCause
  );
`else
  modport slave (
    input  opcode, zero_E, imem_ready, dmem_ready,
    output PcWrite, PcSrc, IrWrite, AluSrc, AluControl, RegWrite,
           MemRead, MemWrite, MemtoReg, busy
  );
  modport master (
    output opcode, zero_E, imem_ready, dmem_ready,
    input  PcWrite, PcSrc, IrWrite, AluSrc, AluControl, RegWrite,
           MemRead, MemWrite, MemtoReg, busy
  );
`endif
endinterface

// File: rtl/mc_exec_controller_alu_decoder.sv
// Combinational instruction class -> ALU control code.
module mc_alu_decoder
  import mc_exec_controller_pkg::*;
(
  input  class_t     cls,
  output logic [3:0] alu_ctl
);

  // Memory ops reuse ADD for address generation; branches pass B for the zero test.
  always_comb begin
    alu_ctl = ALUCTL_AND;
    case (cls)
      CL_ADD, CL_LDUR, CL_STUR: alu_ctl = ALUCTL_ADD;
      CL_SUB:                   alu_ctl = ALUCTL_SUB;
      CL_AND:                   alu_ctl = ALUCTL_AND;
      CL_ORR:                   alu_ctl = ALUCTL_ORR;
      CL_CBZ, CL_B:             alu_ctl = ALUCTL_PASSB;
      default:                  alu_ctl = ALUCTL_AND;
    endcase
  end

endmodule

// File: rtl/mc_exec_controller.sv
// LEGv8 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready waits.
// Define MC_EXC_EN to trap unknown opcodes into a halting EXC state.
module mc_exec_controller
  import mc_exec_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mc_exec_controller_if.slave bus
);

  state_t     state_r, next_state_s;
  class_t     cls_r, dec_cls_s, cls_next_s;
  ctrl_t      ctrl_r, next_ctrl_s;
  logic [3:0] aluctl_r, aluctl_s;
  logic       take_s;
`ifdef MC_EXC_EN
  logic       exc_r;
`endif

  mc_alu_decoder u_alu_dec (
    .cls     (cls_next_s),
    .alu_ctl (aluctl_s)
  );

  // Next-state selection; the class is decoded live in DECODE and latched after.
  always_comb begin
    dec_cls_s    = decode_class(bus.opcode);
    cls_next_s   = (state_r == ST_DECODE) ? dec_cls_s : cls_r;
    next_state_s = ST_FETCH;
    case (state_r)
      ST_FETCH:  next_state_s = bus.imem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (dec_cls_s)
          CL_ADD, CL_SUB, CL_AND, CL_ORR: next_state_s = ST_EXEC_R;
          CL_LDUR, CL_STUR:               next_state_s = ST_ADDR;
          CL_CBZ, CL_B:                   next_state_s = ST_BRANCH;
`ifdef MC_EXC_EN
          default:                        next_state_s = ST_EXC;
`else
          default:                        next_state_s = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R: next_state_s = ST_WB_R;
      ST_WB_R:   next_state_s = ST_FETCH;
      ST_ADDR:   next_state_s = (cls_r == CL_LDUR) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: next_state_s = bus.dmem_ready ? ST_WB_MEM : ST_MEM_RD;
      ST_WB_MEM: next_state_s = ST_FETCH;
      ST_MEM_WR: next_state_s = bus.dmem_ready ? ST_FETCH : ST_MEM_WR;
      ST_BRANCH: next_state_s = ST_FETCH;
      ST_EXC:    next_state_s = ST_EXC;
      default:   next_state_s = ST_FETCH;
    endcase
    next_ctrl_s = state_ctrl(next_state_s);
  end

  // State register with control bits precomputed for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      cls_r    <= CL_NOP;
      ctrl_r   <= state_ctrl(ST_FETCH);
      aluctl_r <= ALUCTL_AND;
`ifdef MC_EXC_EN
      exc_r    <= 1'b0;
`endif
    end else begin
      state_r  <= next_state_s;
      cls_r    <= cls_next_s;
      ctrl_r   <= next_ctrl_s;
      aluctl_r <= state_uses_alu(next_state_s) ? aluctl_s : ALUCTL_AND;
`ifdef MC_EXC_EN
      exc_r    <= (next_state_s == ST_EXC);
`endif
    end
  end

  // Write enables that depend on same-cycle handshakes; reset forces everything quiet.
  always_comb begin
    take_s = ctrl_r.branch & ((cls_r == CL_B) | ((cls_r == CL_CBZ) & bus.zero_E));
    if (reset) begin
      bus.PcWrite    = 1'b0;
      bus.PcSrc      = 1'b0;
      bus.IrWrite    = 1'b0;
      bus.AluSrc     = 1'b0;
      bus.AluControl = ALUCTL_AND;
      bus.RegWrite   = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.MemtoReg   = 1'b0;
      bus.busy       = 1'b0;
`ifdef MC_EXC_EN
      bus.Exc        = 1'b0;
      bus.ExcCause   = EXC_NONE;
`endif
    end else begin
      bus.PcWrite    = (ctrl_r.fetch & bus.imem_ready) | take_s;
      bus.PcSrc      = ctrl_r.branch;
      bus.IrWrite    = ctrl_r.fetch & bus.imem_ready;
      bus.AluSrc     = ctrl_r.alusrc;
      bus.AluControl = aluctl_r;
      bus.RegWrite   = ctrl_r.regwrite;
      bus.MemRead    = ctrl_r.memread;
      bus.MemWrite   = ctrl_r.memwrite;
      bus.MemtoReg   = ctrl_r.memtoreg;
      bus.busy       = ctrl_r.busy;
`ifdef MC_EXC_EN
      bus.Exc        = exc_r;
      bus.ExcCause   = exc_r ? EXC_ILLEGAL_OP : EXC_NONE;
`endif
    end
  end

endmodule
